// File: rtl/simple_log_buffer_if.sv
// ---------------------------------------------------------------------------
// simple_log_buffer_if
//
// Purpose:
//   Bundles the producer write handshake and the single-outstanding read
//   request/response handshake of the simple-log entry store.
//
// Signals:
//   wr_val / wr_data / wr_rdy                 producer entry push
//   log_rd_req_val / log_rd_req_addr /
//   log_rd_req_rdy                            read request (entry index)
//   log_rd_resp_val / log_rd_resp_data /
//   log_rd_resp_rdy                           read response
//
// Modports:
//   master  producer + reader controller side (drives val/data/resp_rdy)
//   slave   the log buffer itself
// ---------------------------------------------------------------------------
interface simple_log_buffer_if #(
    parameter int ADDR_W             = 8,
    parameter int RESP_DATA_STRUCT_W = 64
);
    logic                          wr_val;
    logic [RESP_DATA_STRUCT_W-1:0] wr_data;
    logic                          wr_rdy;

    logic                          log_rd_req_val;
    logic [ADDR_W-1:0]             log_rd_req_addr;
    logic                          log_rd_req_rdy;

    logic                          log_rd_resp_val;
    logic [RESP_DATA_STRUCT_W-1:0] log_rd_resp_data;
    logic                          log_rd_resp_rdy;

    modport master (
        output wr_val,
        output wr_data,
        input  wr_rdy,
        output log_rd_req_val,
        output log_rd_req_addr,
        input  log_rd_req_rdy,
        input  log_rd_resp_val,
        input  log_rd_resp_data,
        output log_rd_resp_rdy
    );

    modport slave (
        input  wr_val,
        input  wr_data,
        output wr_rdy,
        input  log_rd_req_val,
        input  log_rd_req_addr,
        output log_rd_req_rdy,
        output log_rd_resp_val,
        output log_rd_resp_data,
        input  log_rd_resp_rdy
    );
endinterface

// File: rtl/simple_log_buffer.sv
// ---------------------------------------------------------------------------
// simple_log_buffer
//
// Purpose:
//   Circular store of fixed-width log entries feeding the simple-log read
//   datapath. Producers push entries at a wrapping write pointer; a sticky
//   flag records the first wrap. Reads are served one at a time through a
//   single response register with one cycle of latency and full throughput
//   when the consumer keeps up. Asserting freeze halts logging so a host can
//   read a stable snapshot; entries offered while frozen are counted.
//
// Parameters:
//   ADDR_W              log2 of the entry count
//   RESP_DATA_STRUCT_W  entry width in bits
//   SATURATE_DROP_CNT   1 = drop counter sticks at all-ones, 0 = wraps
//
// Ports:
//   clk           clock, all logic on the rising edge
//   rst_n         asynchronous active-low reset
//   freeze        1 = logging halted, writes refused
//   bus           write and read handshakes (slave side)
//   curr_wr_addr  next index to be written (registered)
//   has_wrapped   sticky, write pointer has wrapped at least once
//   drop_cnt      entries refused while frozen
// ---------------------------------------------------------------------------
module simple_log_buffer #(
    parameter int ADDR_W             = 8,
    parameter int RESP_DATA_STRUCT_W = 64,
    parameter int SATURATE_DROP_CNT  = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   freeze,
    simple_log_buffer_if.slave     bus,
    output logic [ADDR_W-1:0]      curr_wr_addr,
    output logic                   has_wrapped,
    output logic [31:0]            drop_cnt
);

    localparam int                DEPTH     = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
    localparam logic [31:0]       DROP_MAX  = 32'hFFFF_FFFF;

    typedef enum logic {
        RD_IDLE,
        RD_RESP
    } rd_state_t;

    logic [RESP_DATA_STRUCT_W-1:0] mem [DEPTH];

    logic                          wr_fire;
    logic                          wr_drop;
    logic                          rd_fire;
    logic                          req_rdy;
    logic                          resp_val;
    logic [RESP_DATA_STRUCT_W-1:0] resp_data;
    logic                          drop_hold;

    rd_state_t                     rd_state;
    rd_state_t                     rd_state_next;

    // Write acceptance depends only on freeze, so producers see it the same
    // cycle they offer an entry.
    assign bus.wr_rdy = ~freeze;
    assign wr_fire    = bus.wr_val & ~freeze;
    assign wr_drop    = bus.wr_val & freeze;

    // A read is taken whenever the response register is free or is being
    // drained in this same cycle.
    assign rd_fire    = bus.log_rd_req_val & req_rdy;

    assign bus.log_rd_req_rdy   = req_rdy;
    assign bus.log_rd_resp_val  = resp_val;
    assign bus.log_rd_resp_data = resp_data;

    // The counter only stops at all-ones when saturation is enabled.
    assign drop_hold = (SATURATE_DROP_CNT != 0) && (drop_cnt == DROP_MAX);

    // Entry storage: a plain dual-port RAM with no reset so it maps onto a
    // block RAM. The read port lives in the response register below; since
    // both update on the same edge, a same-cycle read of the index being
    // written returns the old word.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[curr_wr_addr] <= bus.wr_data;
        end
    end

    // Write pointer and sticky wrap flag. The pointer keeps its position
    // across freeze so logging resumes where it stopped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            curr_wr_addr <= '0;
            has_wrapped  <= 1'b0;
        end else if (wr_fire) begin
            curr_wr_addr <= curr_wr_addr + 1'b1;
            if (curr_wr_addr == LAST_ADDR) begin
                has_wrapped <= 1'b1;
            end
        end
    end

    // Count entries refused while frozen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= '0;
        end else if (wr_drop && !drop_hold) begin
            drop_cnt <= drop_cnt + 32'd1;
        end
    end

    // Read state register; reset drops any outstanding response at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_state <= RD_IDLE;
        end else begin
            rd_state <= rd_state_next;
        end
    end

    // Read next-state and handshake decode. In RESP the request side is
    // pipelined behind the consumer: a new request is only taken while the
    // current response is being accepted, so a stalled response holds still.
    always_comb begin
        rd_state_next = rd_state;
        req_rdy       = 1'b0;
        resp_val      = 1'b0;
        case (rd_state)
            RD_IDLE: begin
                req_rdy = 1'b1;
                if (bus.log_rd_req_val) begin
                    rd_state_next = RD_RESP;
                end
            end
            RD_RESP: begin
                resp_val = 1'b1;
                req_rdy  = bus.log_rd_resp_rdy;
                if (bus.log_rd_resp_rdy && !bus.log_rd_req_val) begin
                    rd_state_next = RD_IDLE;
                end
            end
            default: begin
                rd_state_next = RD_IDLE;
            end
        endcase
    end

    // Response register doubles as the RAM read port: loaded only when a
    // request is accepted, otherwise it holds its word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_data <= '0;
        end else if (rd_fire) begin
            resp_data <= mem[bus.log_rd_req_addr];
        end
    end

endmodule
